// File: rtl/amstrad_pkg.sv
// amstrad_pkg: shared gate-array constants and types for the interrupt generator.
// Holds the GA command decode (mode register select and its interrupt-counter
// reset bit), the default divider/delay values, and the interrupt source enum.
package amstrad_pkg;

  localparam logic [1:0] GA_CMD_MODE     = 2'b10;
  localparam int         GA_INTRST_BIT   = 4;
  localparam int         GA_LINE_DIV_DEF = 52;
  localparam int         GA_VS_DELAY_DEF = 2;

  typedef enum logic {
    SRC_PERIODIC = 1'b0,
    SRC_RASTER   = 1'b1
  } int_src_e;

endpackage

// File: rtl/amstrad_ga_irq_gen_if.sv
// amstrad_ga_irq_gen_if: bus bundle of the gate-array interrupt generator.
//   CE_SAMPLE        1 MHz sampling strobe, one CLK wide
//   crtc_hs/crtc_vs  CRTC HSYNC / VSYNC
//   WE, D[7:0]       gate-array write strobe and data (port 7Fxx)
//   INTack           Z80 interrupt acknowledge, one CLK wide
//   pri_we, pri_line programmable raster interrupt line write (0 disables)
//   INT              interrupt request level
//   int_src          0 = periodic source, 1 = raster source
//   irq_cnt          interrupt line counter
//   line_cnt         raster line since VSYNC
// master drives the stimulus side, slave is the generator itself.
interface amstrad_ga_irq_gen_if #(
  parameter int CNT_W  = 6,
  parameter int LINE_W = 9
);

  logic              CE_SAMPLE;
  logic              crtc_hs;
  logic              crtc_vs;
  logic              WE;
  logic [7:0]        D;
  logic              INTack;
  logic              pri_we;
  logic [LINE_W-1:0] pri_line;
  logic              INT;
  logic              int_src;
  logic [CNT_W-1:0]  irq_cnt;
  logic [LINE_W-1:0] line_cnt;

  modport master (
    output CE_SAMPLE, crtc_hs, crtc_vs, WE, D, INTack, pri_we, pri_line,
    input  INT, int_src, irq_cnt, line_cnt
  );

  modport slave (
    input  CE_SAMPLE, crtc_hs, crtc_vs, WE, D, INTack, pri_we, pri_line,
    output INT, int_src, irq_cnt, line_cnt
  );

endinterface

// File: rtl/amstrad_sync_edge.sv
// amstrad_sync_edge: CE-gated HSYNC/VSYNC sampler producing edge pulses.
//   CLK, RESET_N        clock, synchronous active-low reset
//   CE_SAMPLE           sampling strobe; edges are only seen on these cycles
//   crtc_hs, crtc_vs    raw CRTC syncs
//   hs_fall, vs_rise    one-CLK edge pulses, valid in the CE_SAMPLE cycle
module amstrad_sync_edge (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CE_SAMPLE,
  input  logic crtc_hs,
  input  logic crtc_vs,
  output logic hs_fall,
  output logic vs_rise
);

  logic old_hs, old_vs;

  always_ff @(posedge CLK)
    if (!RESET_N) begin
      old_hs <= 1'b0;
      old_vs <= 1'b0;
    end else if (CE_SAMPLE) begin
      old_hs <= crtc_hs;
      old_vs <= crtc_vs;
    end

  // Compare the live sync against the previous sample so the edge is
  // reported in the same cycle that samples it.
  assign hs_fall = CE_SAMPLE & old_hs & ~crtc_hs;
  assign vs_rise = CE_SAMPLE & ~old_vs & crtc_vs;

endmodule

// File: rtl/amstrad_ga_irq_gen.sv
// amstrad_ga_irq_gen: gate-array interrupt generator (HSYNC divider with
// VSYNC resync, Z80 acknowledge and GA counter-reset write).
//   CLK, RESET_N  clock, synchronous active-low reset
//   bus           amstrad_ga_irq_gen_if.slave (syncs, GA write, ack, PRI,
//                 INT / int_src / irq_cnt / line_cnt)
// Build option GA_PRI_EN adds the Plus-style programmable raster interrupt;
// without it the PRI inputs are ignored, line_cnt and int_src read 0.
module amstrad_ga_irq_gen
  import amstrad_pkg::*;
#(
  parameter int LINE_DIV  = GA_LINE_DIV_DEF,
  parameter int CNT_W     = 6,
  parameter int GUARD_BIT = 5,
  parameter int VS_DELAY  = GA_VS_DELAY_DEF,
  parameter int LINE_W    = 9
) (
  input logic CLK,
  input logic RESET_N,
  amstrad_ga_irq_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] WRAP_AT    = CNT_W'(LINE_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_MASK = CNT_W'(1) << GUARD_BIT;

  logic                hs_fall, vs_rise;
  logic [CNT_W-1:0]    irq_cnt, cnt_step, cnt_nxt;
  logic [VS_DELAY-1:0] dly, dly_nxt;
  logic                per_pend, per_nxt, per_set;
  logic                ras_pend, ras_nxt, ras_set;
  logic                wrap, resync, cnt_rst, pri_on;
  logic [LINE_W-1:0]   line_cnt, line_nxt, pri_reg, pri_nxt;
  logic                unused_d;

  amstrad_sync_edge u_sync (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .CE_SAMPLE(bus.CE_SAMPLE),
    .crtc_hs  (bus.crtc_hs),
    .crtc_vs  (bus.crtc_vs),
    .hs_fall  (hs_fall),
    .vs_rise  (vs_rise)
  );

`ifdef GA_PRI_EN
  assign pri_on   = |pri_reg;
  assign ras_set  = hs_fall & pri_on & (line_cnt == pri_reg);
  assign line_nxt = vs_rise ? '0 : (hs_fall & ~&line_cnt) ? line_cnt + 1'b1 : line_cnt;
  assign pri_nxt  = bus.pri_we ? bus.pri_line : pri_reg;
`else
  logic unused_pri;
  assign pri_on     = 1'b0;
  assign ras_set    = 1'b0;
  assign line_nxt   = '0;
  assign pri_nxt    = '0;
  assign unused_pri = ^{bus.pri_we, bus.pri_line, pri_reg};
`endif

  assign unused_d = ^{bus.D[5], bus.D[3:0]};

  always_comb begin
    wrap     = hs_fall & (irq_cnt == WRAP_AT);
    // Delay register MSB set means this HSYNC is the VS_DELAY-th since VSYNC.
    resync   = hs_fall & dly[VS_DELAY-1];
    cnt_rst  = bus.WE & (bus.D[7:6] == GA_CMD_MODE) & bus.D[GA_INTRST_BIT];
    // Resync only fires if the guard bit shows the line was late in the period.
    per_set  = (wrap | (resync & irq_cnt[GUARD_BIT])) & ~pri_on;
    cnt_step = (wrap | resync) ? '0 : hs_fall ? irq_cnt + 1'b1 : irq_cnt;
    cnt_nxt  = cnt_rst ? '0 : bus.INTack ? (cnt_step & ~GUARD_MASK) : cnt_step;
    dly_nxt  = vs_rise ? VS_DELAY'(1) : hs_fall ? (dly << 1) : dly;
    // The raster source is reported first, so an ack retires it before periodic.
    ras_nxt  = (ras_pend | ras_set) & ~bus.INTack;
    per_nxt  = ~cnt_rst & (per_pend | per_set) & ~(bus.INTack & ~(ras_pend | ras_set));
  end

  always_ff @(posedge CLK)
    if (!RESET_N) begin
      irq_cnt  <= '0;
      dly      <= '0;
      per_pend <= 1'b0;
      ras_pend <= 1'b0;
      line_cnt <= '0;
      pri_reg  <= '0;
    end else begin
      irq_cnt  <= cnt_nxt;
      dly      <= dly_nxt;
      per_pend <= per_nxt;
      ras_pend <= ras_nxt;
      line_cnt <= line_nxt;
      pri_reg  <= pri_nxt;
    end

  assign bus.INT      = per_pend | ras_pend;
  assign bus.int_src  = ras_pend ? SRC_RASTER : SRC_PERIODIC;
  assign bus.irq_cnt  = irq_cnt;
  assign bus.line_cnt = line_cnt;

endmodule
